osd_dbg_num_writer: RTL and testbench

OSD_DBG_NUM_WRITER -- requirements
Module: osd_dbg_num_writer

---
 rtl/osd_dbg_num_writer_if.sv | 40 ++++
 rtl/osd_dbg_num_writer.sv | 201 ++++++++++++++++++++
 tb/tb_osd_dbg_num_writer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/osd_dbg_num_writer_if.sv
// Port bundle of the OSD debug number writer: request side, converter side and char RAM write port.
// The slave modport is the writer's view; master is the surrounding system's view.
interface osd_dbg_num_writer_if #(
    parameter int ADDR_W = 11
);
    logic              req;
    logic [13:0]       value;
    logic [5:0]        col;
    logic [4:0]        row;
    logic              blank_lz;
    logic              busy;
    logic              ack;
    logic              err;

    logic              conv_start;
    logic [13:0]       conv_bin;
    logic              conv_done;
    logic [7:0]        dig_th;
    logic [7:0]        dig_hu;
    logic [7:0]        dig_te;
    logic [7:0]        dig_un;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;

    modport slave (
        input  req, value, col, row, blank_lz,
        input  conv_done, dig_th, dig_hu, dig_te, dig_un,
        output busy, ack, err, conv_start, conv_bin,
        output ram_we, ram_addr, ram_data
    );

    modport master (
        output req, value, col, row, blank_lz,
        output conv_done, dig_th, dig_hu, dig_te, dig_un,
        input  busy, ack, err, conv_start, conv_bin,
        input  ram_we, ram_addr, ram_data
    );
endinterface

// File: rtl/osd_dbg_num_writer.sv
// Prints a 4-digit decimal number into the OSD char RAM: converts via an external
// binary-to-ASCII block, then writes thousands..units with optional leading-zero blanking.
module osd_dbg_num_writer #(
    parameter int COLS    = 40,
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 32
) (
    input logic                clk,
    input logic                reset,
    osd_dbg_num_writer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        ACK   = 3'd4
    } state_t;

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [13:0]      MAX_VAL  = 14'd9999;
    localparam logic [31:0]      COLS_U   = 32'(COLS);

    // Cell address of digit k; the column wraps within the same row.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] r,
                                                    input logic [5:0] c,
                                                    input logic [1:0] k);
        logic [31:0] col_sum;
        logic [31:0] full;
        col_sum = {26'd0, c} + {30'd0, k};
        full    = ({27'd0, r} * COLS_U) + (col_sum % COLS_U);
        return full[ADDR_W-1:0];
    endfunction

    // Character for digit k; a digit is blanked only if it and everything left of it is '0'.
    function automatic logic [7:0] cell_char(input logic [3:0][7:0] d,
                                             input logic [1:0]      k,
                                             input logic            bl);
        logic lead;
        lead = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if ((2'(j) <= k) && (d[j] != 8'h30)) begin
                lead = 1'b0;
            end else begin
                lead = lead;
            end
        end
        if (bl && (k != 2'd3) && lead) begin
            return 8'h20;
        end else begin
            return d[k];
        end
    endfunction

    state_t            state_r, state_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic [1:0]        idx_r, idx_n;
    logic [5:0]        col_r, col_n;
    logic [4:0]        row_r, row_n;
    logic              blank_r, blank_n;
    logic [3:0][7:0]   dig_r, dig_n;
    logic [3:0][7:0]   dig_in_s;

    logic              conv_start_r, conv_start_n;
    logic [13:0]       conv_bin_r, conv_bin_n;
    logic              ram_we_r, ram_we_n;
    logic [ADDR_W-1:0] ram_addr_r, ram_addr_n;
    logic [7:0]        ram_data_r, ram_data_n;
    logic              busy_r, busy_n;
    logic              ack_r, ack_n;
    logic              err_r, err_n;

    assign dig_in_s = {bus.dig_un, bus.dig_te, bus.dig_hu, bus.dig_th};

    assign bus.conv_start = conv_start_r;
    assign bus.conv_bin   = conv_bin_r;
    assign bus.ram_we     = ram_we_r;
    assign bus.ram_addr   = ram_addr_r;
    assign bus.ram_data   = ram_data_r;
    assign bus.busy       = busy_r;
    assign bus.ack        = ack_r;
    assign bus.err        = err_r;

    // State, captured request/digits and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            idx_r        <= 2'd0;
            col_r        <= 6'd0;
            row_r        <= 5'd0;
            blank_r      <= 1'b0;
            dig_r        <= '0;
            conv_start_r <= 1'b0;
            conv_bin_r   <= 14'd0;
            ram_we_r     <= 1'b0;
            ram_addr_r   <= '0;
            ram_data_r   <= 8'd0;
            busy_r       <= 1'b0;
            ack_r        <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            idx_r        <= idx_n;
            col_r        <= col_n;
            row_r        <= row_n;
            blank_r      <= blank_n;
            dig_r        <= dig_n;
            conv_start_r <= conv_start_n;
            conv_bin_r   <= conv_bin_n;
            ram_we_r     <= ram_we_n;
            ram_addr_r   <= ram_addr_n;
            ram_data_r   <= ram_data_n;
            busy_r       <= busy_n;
            ack_r        <= ack_n;
            err_r        <= err_n;
        end
    end

    // Next state plus the output values that belong to the cycle the FSM moves into.
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        idx_n        = idx_r;
        col_n        = col_r;
        row_n        = row_r;
        blank_n      = blank_r;
        dig_n        = dig_r;
        conv_start_n = 1'b0;
        conv_bin_n   = conv_bin_r;
        ram_we_n     = 1'b0;
        ram_addr_n   = ram_addr_r;
        ram_data_n   = ram_data_r;
        ack_n        = 1'b0;
        err_n        = 1'b0;

        case (state_r)
            IDLE: begin
                if (bus.req) begin
                    col_n        = bus.col;
                    row_n        = bus.row;
                    blank_n      = bus.blank_lz;
                    conv_bin_n   = (bus.value > MAX_VAL) ? MAX_VAL : bus.value;
                    conv_start_n = 1'b1;
                    state_n      = START;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // err is already showing in the cycle the counter holds TIMEOUT; a late done is dropped.
                if (cnt_r == CNT_TO) begin
                    state_n = IDLE;
                end else if (bus.conv_done) begin
                    dig_n    = dig_in_s;
                    idx_n    = 2'd0;
                    ram_we_n = 1'b1;
                    state_n  = WRITE;
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                    err_n = (cnt_r == CNT_LAST);
                end
            end
            WRITE: begin
                if (idx_r == 2'd3) begin
                    ack_n   = 1'b1;
                    state_n = ACK;
                end else begin
                    idx_n    = idx_r + 2'd1;
                    ram_we_n = 1'b1;
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (ram_we_n) begin
            ram_addr_n = cell_addr(row_r, col_r, idx_n);
            ram_data_n = cell_char(dig_n, idx_n, blank_r);
        end else begin
            ram_addr_n = ram_addr_r;
            ram_data_n = ram_data_r;
        end

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_osd_dbg_num_writer.sv
// Randomized bench for osd_dbg_num_writer: a converter/RAM model drives the DUT and every
// cycle is compared against expectations computed from decimal arithmetic on the request.
module tb_osd_dbg_num_writer;

    localparam int COLS    = 40;
    localparam int ADDR_W  = 11;
    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   ram_writes = 0;
    logic [7:0] mem [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    osd_dbg_num_writer_if #(.ADDR_W(ADDR_W)) bus();

    osd_dbg_num_writer #(
        .COLS(COLS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Char RAM: commits whatever write port is active at the clock edge.
    always @(posedge clk) begin
        if (bus.ram_we === 1'b1) begin
            mem[bus.ram_addr] = bus.ram_data;
            ram_writes++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampv(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic int pw10(input int k);
        int p;
        p = 1;
        for (int i = 0; i < 3 - k; i++) p = p * 10;
        return p;
    endfunction

    // Leading zero means the whole number is smaller than this digit's place value.
    function automatic logic [7:0] exp_char(input int v, input int k, input bit bl);
        if (bl && k < 3 && v < pw10(k)) return 8'h20;
        return 8'(48 + (v / pw10(k)) % 10);
    endfunction

    function automatic int exp_addr(input int r, input int c, input int k);
        return (r * COLS + (c + k) % COLS) % (1 << ADDR_W);
    endfunction

    task automatic set_digs(input int v);
        bus.dig_th = 8'(48 + (v / 1000) % 10);
        bus.dig_hu = 8'(48 + (v / 100) % 10);
        bus.dig_te = 8'(48 + (v / 10) % 10);
        bus.dig_un = 8'(48 + v % 10);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_conv_start"}, 32'(bus.conv_start), 32'd0);
        check_val({tag, "_conv_bin"},   32'(bus.conv_bin),   32'd0);
        check_val({tag, "_ram_we"},     32'(bus.ram_we),     32'd0);
        check_val({tag, "_ram_addr"},   32'(bus.ram_addr),   32'd0);
        check_val({tag, "_ram_data"},   32'(bus.ram_data),   32'd0);
        check_val({tag, "_busy"},       32'(bus.busy),       32'd0);
        check_val({tag, "_ack"},        32'(bus.ack),        32'd0);
        check_val({tag, "_err"},        32'(bus.err),        32'd0);
    endtask

    // One request from IDLE to back in IDLE; lat = cycles from START to conv_done.
    task automatic run_txn(input int v, input int c0, input int r0, input bit bl,
                           input int lat, input bit tmo, input bit noise);
        int cv;
        int endc;
        int k;
        bit ewe;
        cv   = clampv(v);
        endc = tmo ? TIMEOUT + 2 : lat + 6;
        bus.req      = 1'b1;
        bus.value    = 14'(v);
        bus.col      = 6'(c0);
        bus.row      = 5'(r0);
        bus.blank_lz = bl;
        tick();
        for (int c = 0; c <= endc; c++) begin
            ewe = !tmo && c >= lat + 1 && c <= lat + 4;
            check_val("conv_start", 32'(bus.conv_start), 32'(c == 0));
            check_val("conv_bin",   32'(bus.conv_bin),   32'(cv));
            check_val("busy",       32'(bus.busy),       32'(c < endc));
            check_val("ram_we",     32'(bus.ram_we),     32'(ewe));
            check_val("ack",        32'(bus.ack),        32'(!tmo && c == lat + 5));
            check_val("err",        32'(bus.err),        32'(tmo && c == TIMEOUT + 1));
            if (ewe) begin
                k = c - lat - 1;
                check_val("ram_addr", 32'(bus.ram_addr), 32'(exp_addr(r0, c0, k)));
                check_val("ram_data", 32'(bus.ram_data), 32'(exp_char(cv, k, bl)));
            end
            bus.req = noise && (c < endc) && ($urandom_range(0, 2) == 0);
            if (bus.req) begin
                bus.value    = 14'($urandom);
                bus.col      = 6'($urandom);
                bus.row      = 5'($urandom);
                bus.blank_lz = 1'($urandom);
            end
            if (!tmo && c == lat) begin
                bus.conv_done = 1'b1;
                set_digs(cv);
            end else if (noise && !tmo && (c == 0 || c > lat) && $urandom_range(0, 1) == 1) begin
                bus.conv_done = 1'b1;
                set_digs(int'($urandom_range(0, 9999)));
            end else begin
                bus.conv_done = 1'b0;
            end
            tick();
        end
        bus.req       = 1'b0;
        bus.conv_done = 1'b0;
    endtask

    task automatic reset_mid_write();
        int w0;
        mem[125] = 8'h00;
        mem[126] = 8'h00;
        bus.req      = 1'b1;
        bus.value    = 14'd5678;
        bus.col      = 6'd5;
        bus.row      = 5'd3;
        bus.blank_lz = 1'b0;
        tick();
        bus.req = 1'b0;
        w0 = ram_writes;
        for (int c = 0; c < 4; c++) begin
            bus.conv_done = (c == 2);
            set_digs(5678);
            tick();
        end
        bus.conv_done = 1'b0;
        check_val("rst_pre_we", 32'(bus.ram_we), 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("rst_writes", 32'(ram_writes - w0), 32'd1);
        check_val("rst_mem0",   32'(mem[125]), 32'h35);
        check_val("rst_mem1",   32'(mem[126]), 32'h00);
        tick();
        check_val("rst_post_we",   32'(bus.ram_we), 32'd0);
        check_val("rst_post_busy", 32'(bus.busy),   32'd0);
        check_val("rst_post_wcnt", 32'(ram_writes - w0), 32'd1);
    endtask

    initial begin
        int v;
        bus.req       = 1'b0;
        bus.value     = 14'd0;
        bus.col       = 6'd0;
        bus.row       = 5'd0;
        bus.blank_lz  = 1'b0;
        bus.conv_done = 1'b0;
        set_digs(0);
        reset = 1'b1;
        #1;
        check_all_zero("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_all_zero("post_reset");

        run_txn(1234, 0, 2, 1'b0, 1, 1'b0, 1'b0);
        check_val("mem80", 32'(mem[80]), 32'h31);
        check_val("mem83", 32'(mem[83]), 32'h34);
        run_txn(7,     10, 0, 1'b1, 3, 1'b0, 1'b0);
        run_txn(0,     10, 0, 1'b1, 2, 1'b0, 1'b0);
        run_txn(16383,  5, 4, 1'b0, 1, 1'b0, 1'b0);
        run_txn(4321,  38, 1, 1'b0, 2, 1'b0, 1'b0);
        check_val("mem41", 32'(mem[41]), 32'h31);
        run_txn(1050,  63, 31, 1'b1, 4, 1'b0, 1'b1);
        run_txn(55,     3, 3, 1'b0, 1, 1'b1, 1'b1);
        reset_mid_write();
        run_txn(1234,   0, 2, 1'b0, 1, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       v = int'($urandom_range(0, 9));
                1:       v = int'($urandom_range(0, 999));
                2:       v = int'($urandom_range(0, 9999));
                3:       v = int'($urandom_range(10000, 16383));
                default: v = int'($urandom_range(0, 16383));
            endcase
            run_txn(v, int'($urandom_range(0, 63)), int'($urandom_range(0, 31)),
                    1'($urandom), int'($urandom_range(1, 6)),
                    ($urandom_range(0, 9) == 0), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
